hdmi_timing_gen: RTL and testbench

HDMI_TIMING_GEN -- requirements
Module: hdmi_timing_gen

---
 rtl/hdmi_timing_gen.sv | 134 +++++++++++++
 tb/tb_hdmi_timing_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hdmi_timing_gen.sv
// Video timing generator that locks a YCbCr 4:2:2 pixel stream to the raster
// and formats it for an HDMI transmitter. Underflow and SOF errors are counted.
module hdmi_timing_gen #(
  parameter int   H_ACTIVE = 1920,
  parameter int   H_FP     = 88,
  parameter int   H_SYNC   = 44,
  parameter int   H_BP     = 148,
  parameter int   V_ACTIVE = 1080,
  parameter int   V_FP     = 4,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 36,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  input  logic        pix_sof,
  output logic        pix_ready,
  output logic        data_enable,
  output logic        hsync,
  output logic        vsync,
  output logic [23:0] data_HDMI,
  output logic [15:0] underflow_cnt,
  output logic [15:0] sof_err_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [23:0] BLACK = 24'h80_10_00;

  typedef enum logic {WAIT_SOF, RUN} state_t;

  state_t          state, state_next;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            active, origin, hs_region, vs_region;
  logic            de_next;
  logic [23:0]     data_next;
  logic            underflow_evt, sof_evt;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign origin    = (h_cnt == '0) && (v_cnt == '0);
  assign hs_region = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vs_region = (v_cnt >= V_SS) && (v_cnt < V_SE);

  always_comb begin
    state_next    = state;
    pix_ready     = 1'b0;
    de_next       = 1'b0;
    data_next     = '0;
    underflow_evt = 1'b0;
    sof_evt       = 1'b0;
    case (state)
      WAIT_SOF: begin
        // Junk beats drain freely; the SOF beat waits for the raster origin.
        pix_ready = pix_valid && (!pix_sof || origin);
        if (active) begin
          de_next   = 1'b1;
          data_next = BLACK;
        end
        if (pix_valid && pix_sof && origin) begin
          state_next = RUN;
          data_next  = {pix_data, 8'h00};
        end
      end
      RUN: begin
        pix_ready = active;
        if (active) begin
          de_next = 1'b1;
          if (pix_valid) begin
            data_next = {pix_data, 8'h00};
            if (pix_sof != origin) begin
              sof_evt    = 1'b1;
              state_next = WAIT_SOF;
            end
          end else begin
            data_next     = BLACK;
            underflow_evt = 1'b1;
            state_next    = WAIT_SOF;
          end
        end
      end
    endcase
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state         <= WAIT_SOF;
      data_enable   <= 1'b0;
      hsync         <= ~HS_POL;
      vsync         <= ~VS_POL;
      data_HDMI     <= '0;
      underflow_cnt <= '0;
      sof_err_cnt   <= '0;
    end else begin
      state       <= state_next;
      data_enable <= de_next;
      hsync       <= hs_region ? HS_POL : ~HS_POL;
      vsync       <= vs_region ? VS_POL : ~VS_POL;
      data_HDMI   <= data_next;
      if (underflow_evt && (underflow_cnt != 16'hFFFF))
        underflow_cnt <= underflow_cnt + 16'd1;
      if (sof_evt && (sof_err_cnt != 16'hFFFF))
        sof_err_cnt <= sof_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Directed bench for hdmi_timing_gen on a 14x7 raster (8x4 active) with a
// scripted pixel source; edge n after reset release shows raster position n.
module tb_hdmi_timing_gen;

  localparam int          HT    = 14;
  localparam int          VT    = 7;
  localparam int          FT    = HT * VT;
  localparam logic [23:0] BLACK = 24'h80_10_00;

  logic        pixel_clk = 1'b0;
  logic        reset     = 1'b1;
  logic [15:0] pix_data  = '0;
  logic        pix_valid = 1'b0;
  logic        pix_sof   = 1'b0;
  logic        pix_ready;
  logic        data_enable, hsync, vsync;
  logic [23:0] data_HDMI;
  logic [15:0] underflow_cnt, sof_err_cnt;

  int   checks = 0;
  int   errors = 0;
  int   beat, n, cur_n, junk, drop_n;
  bit   misplace;
  logic last_ready, took;

  hdmi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .pixel_clk    (pixel_clk),
    .reset        (reset),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .pix_ready    (pix_ready),
    .data_enable  (data_enable),
    .hsync        (hsync),
    .vsync        (vsync),
    .data_HDMI    (data_HDMI),
    .underflow_cnt(underflow_cnt),
    .sof_err_cnt  (sof_err_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] word(input int k);
    return {8'(8'h40 + k), 8'(k), 8'h00};
  endfunction

  function automatic int h_of(input int m);
    return (m % FT) % HT;
  endfunction

  function automatic int v_of(input int m);
    return (m % FT) / HT;
  endfunction

  function automatic int pix_of(input int m);
    return v_of(m) * 8 + h_of(m);
  endfunction

  // Source: `junk` non-SOF beats, then a pixel stream with SOF every 32 beats.
  task automatic drive_src();
    int k;
    pix_valid = (n != drop_n);
    if (beat < junk) begin
      pix_data = 16'hEE00 | 16'(beat);
      pix_sof  = 1'b0;
    end else begin
      k        = beat - junk;
      pix_data = {8'(8'h40 + k), 8'(k)};
      pix_sof  = ((k % 32) == 0) || (misplace && (k == 16));
    end
  endtask

  task automatic step();
    @(negedge pixel_clk);
    last_ready = pix_ready;
    took       = pix_valid && pix_ready;
    @(posedge pixel_clk);
    #1;
    if (took) beat++;
    cur_n = n;
    n++;
    drive_src();
  endtask

  task automatic check_cycle(input int m, input logic [23:0] exp_act);
    int  h, v;
    bit  act;
    h   = h_of(m);
    v   = v_of(m);
    act = (h < 8) && (v < 4);
    check($sformatf("de@%0d", m), 32'(data_enable), 32'(act));
    check($sformatf("hs@%0d", m), 32'(hsync), 32'(h == 10 || h == 11));
    check($sformatf("vs@%0d", m), 32'(vsync), 32'(v == 5));
    check($sformatf("data@%0d", m), 32'(data_HDMI), act ? 32'(exp_act) : 32'h0);
  endtask

  task automatic do_reset(input int j, input bit mp, input int dn);
    reset    = 1'b1;
    junk     = j;
    misplace = mp;
    drop_n   = dn;
    beat     = 0;
    n        = 0;
    drive_src();
    repeat (2) @(posedge pixel_clk);
    #1;
    check("rst_de", 32'(data_enable), 32'h0);
    check("rst_hs", 32'(hsync), 32'h0);
    check("rst_vs", 32'(vsync), 32'h0);
    check("rst_data", 32'(data_HDMI), 32'h0);
    check("rst_ufl", 32'(underflow_cnt), 32'h0);
    check("rst_sof", 32'(sof_err_cnt), 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    // Lock at origin, two frames of continuous valid pixels.
    do_reset(0, 1'b0, -1);
    repeat (2 * FT) begin
      step();
      check_cycle(cur_n, word((cur_n / FT) * 32 + pix_of(cur_n)));
    end
    check("lock_ufl", 32'(underflow_cnt), 32'h0);
    check("lock_sof", 32'(sof_err_cnt), 32'h0);
    $display("lock/sync: checks=%0d errors=%0d", checks, errors);

    // Underflow at line 1 pixel 3; resync on next frame.
    do_reset(0, 1'b0, 17);
    while (n <= FT + 30) begin
      step();
      if (cur_n < FT && pix_of(cur_n) >= 11)
        check_cycle(cur_n, BLACK);
      else
        check_cycle(cur_n, word((cur_n / FT) * 32 + pix_of(cur_n)));
      if (cur_n == 25) check("ufl_discard_rdy", 32'(last_ready), 32'h1);
      if (cur_n == 50) check("ufl_hold_rdy", 32'(last_ready), 32'h0);
    end
    check("ufl_cnt", 32'(underflow_cnt), 32'h1);
    check("ufl_sof", 32'(sof_err_cnt), 32'h0);
    $display("underflow: checks=%0d errors=%0d", checks, errors);

    // Asynchronous reset in the middle of line 2.
    #2;
    reset = 1'b1;
    #1;
    check("arst_de", 32'(data_enable), 32'h0);
    check("arst_data", 32'(data_HDMI), 32'h0);
    check("arst_ufl", 32'(underflow_cnt), 32'h0);
    do_reset(0, 1'b0, -1);
    repeat (HT) begin
      step();
      check_cycle(cur_n, word(pix_of(cur_n)));
    end
    $display("mid-line reset: checks=%0d errors=%0d", checks, errors);

    // Five junk beats ahead of SOF; display starts on the second frame.
    do_reset(5, 1'b0, -1);
    repeat (2 * FT) begin
      step();
      check_cycle(cur_n, (cur_n < FT) ? BLACK : word(pix_of(cur_n)));
      if (cur_n == 2)  check("junk_rdy", 32'(last_ready), 32'h1);
      if (cur_n == 50) check("sof_hold_rdy", 32'(last_ready), 32'h0);
    end
    check("junk_ufl", 32'(underflow_cnt), 32'h0);
    check("junk_sof", 32'(sof_err_cnt), 32'h0);
    $display("junk before sof: checks=%0d errors=%0d", checks, errors);

    // Misplaced SOF at line 2 pixel 0.
    do_reset(0, 1'b1, -1);
    repeat (2 * FT) begin
      step();
      if (cur_n < FT && pix_of(cur_n) > 16)
        check_cycle(cur_n, BLACK);
      else
        check_cycle(cur_n, word((cur_n / FT) * 32 + pix_of(cur_n)));
    end
    check("msof_cnt", 32'(sof_err_cnt), 32'h1);
    check("msof_ufl", 32'(underflow_cnt), 32'h0);
    $display("misplaced sof: checks=%0d errors=%0d", checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
